// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Load/store stage between execute and writeback. Accepts one operation at a
//   time, performs sub-word loads/stores over a req/ack RAM port with a bounded
//   wait, and registers the writeback control that travels with each operation.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, addr, data_in       operation from execute (addr = ALU result)
//   MemRead, MemWrite, funct3     command and RISC-V size code
//   in_MemToReg, in_RegWrite,
//   in_RegDataSrc, in_PCSrc,
//   in_RegDest                    writeback control passthrough
//   stall                         upstream holds inputs while high
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb          RAM request (word-aligned, byte strobes)
//   mem_rdata, mem_ack            RAM read data and completion
//   out_valid                     one-cycle pulse per completed operation
//   data_out, out_AluResult       extended load data, registered address
//   out_MemToReg, out_RegWrite,
//   out_RegDataSrc, out_PCSrc,
//   out_RegDest                   registered writeback control
//   misaligned, bus_err           fault flags, valid with out_valid
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   data_in,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic              in_MemToReg,
   input  logic              in_RegWrite,
   input  logic              in_RegDataSrc,
   input  logic              in_PCSrc,
   input  logic [4:0]        in_RegDest,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   output logic [XLEN-1:0]   data_out,
   output logic [XLEN-1:0]   out_AluResult,
   output logic              out_MemToReg,
   output logic              out_RegWrite,
   output logic              out_RegDataSrc,
   output logic              out_PCSrc,
   output logic [4:0]        out_RegDest,
   output logic              misaligned,
   output logic              bus_err
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CNTW = $clog2(TIMEOUT + 1);
   // Control bundle layout: {MemToReg, RegWrite, RegDataSrc, PCSrc, RegDest[4:0]}
   localparam logic [8:0] NO_REGWRITE = 9'h17F;

   typedef enum logic {IDLE, REQ} state_t;

   // funct3 111 never exists; D and WU only exist on a 64-bit datapath.
   function automatic logic illegal_op(input logic [2:0] f);
      return (f == 3'b111) || ((XLEN == 32) && ((f == 3'b011) || (f == 3'b110)));
   endfunction

   function automatic logic misalign(input logic [2:0] f, input logic [OFFW-1:0] off);
      logic r;
      case (f[1:0])
         2'b01:   r = off[0];
         2'b10:   r = (off[1:0] != 2'b00);
         2'b11:   r = (off != '0);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [NB-1:0] wstrb_of(input logic [2:0] f, input logic [OFFW-1:0] off);
      logic [NB-1:0] m;
      case (f[1:0])
         2'b00:   m = NB'(1);
         2'b01:   m = NB'(3);
         2'b10:   m = NB'(15);
         default: m = NB'(255);
      endcase
      return m << off;
   endfunction

   // Replicating the low bytes into every lane lets the strobes pick the lane.
   function automatic logic [XLEN-1:0] wdata_of(input logic [2:0] f, input logic [XLEN-1:0] d);
      logic [XLEN-1:0] r;
      case (f[1:0])
         2'b00:   r = {NB{d[7:0]}};
         2'b01:   r = {(NB/2){d[15:0]}};
         2'b10:   r = {(NB/4){d[31:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   // Size casts of signed operands sign-extend; of unsigned operands zero-extend.
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f, input logic [XLEN-1:0] rd,
                                                input logic [OFFW-1:0] off);
      logic [XLEN-1:0]   lane;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      logic [XLEN-1:0]   r;
      lane = rd >> {off, 3'b000};
      b    = lane[7:0];
      h    = lane[15:0];
      w    = lane[31:0];
      case (f)
         3'b000:  r = XLEN'(b);
         3'b001:  r = XLEN'(h);
         3'b010:  r = XLEN'(w);
         3'b100:  r = XLEN'(lane[7:0]);
         3'b101:  r = XLEN'(lane[15:0]);
         3'b110:  r = XLEN'(lane[31:0]);
         default: r = lane;
      endcase
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             ov_q, ov_d;
   logic [XLEN-1:0]  dout_q, dout_d;
   logic [XLEN-1:0]  alu_q, alu_d;
   logic [8:0]       octl_q, octl_d;
   logic             mis_q, mis_d;
   logic             berr_q, berr_d;
   logic             cap;

   logic [XLEN-1:0]  op_addr_q;
   logic [2:0]       op_f3_q;
   logic             op_we_q;
   logic [XLEN-1:0]  op_wdata_q;
   logic [NB-1:0]    op_wstrb_q;
   logic [8:0]       op_ctl_q;

   logic [8:0]       in_ctl;
   logic             is_mem;
   logic             fault;

   assign in_ctl = {in_MemToReg, in_RegWrite, in_RegDataSrc, in_PCSrc, in_RegDest};
   assign is_mem = MemRead | MemWrite;
   assign fault  = illegal_op(funct3) | misalign(funct3, addr[OFFW-1:0]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ov_d    = 1'b0;
      dout_d  = dout_q;
      alu_d   = alu_q;
      octl_d  = octl_q;
      mis_d   = mis_q;
      berr_d  = berr_q;
      cap     = 1'b0;
      case (state_q)
         // Accept boundary: operation enters the stage
         IDLE: begin
            if (in_valid) begin
               cap = 1'b1;
               if (!is_mem) begin
                  ov_d   = 1'b1;
                  dout_d = '0;
                  alu_d  = addr;
                  octl_d = in_ctl;
                  mis_d  = 1'b0;
                  berr_d = 1'b0;
               end else if (fault) begin
                  ov_d   = 1'b1;
                  dout_d = '0;
                  alu_d  = addr;
                  octl_d = in_ctl & NO_REGWRITE;
                  mis_d  = 1'b1;
                  berr_d = 1'b0;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
               end
            end
         end
         // Completion boundary: RAM answers or the wait budget runs out
         REQ: begin
            if (mem_ack) begin
               state_d = IDLE;
               cnt_d   = '0;
               ov_d    = 1'b1;
               dout_d  = op_we_q ? '0 : load_ext(op_f3_q, mem_rdata, op_addr_q[OFFW-1:0]);
               alu_d   = op_addr_q;
               octl_d  = op_ctl_q;
               mis_d   = 1'b0;
               berr_d  = 1'b0;
            end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               ov_d    = 1'b1;
               dout_d  = '0;
               alu_d   = op_addr_q;
               octl_d  = op_ctl_q & NO_REGWRITE;
               mis_d   = 1'b0;
               berr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         dout_q  <= '0;
         alu_q   <= '0;
         octl_q  <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
         dout_q  <= dout_d;
         alu_q   <= alu_d;
         octl_q  <= octl_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   // Operation holding registers: only observed while a request is in flight.
   always_ff @(posedge clk) begin
      if (cap) begin
         op_addr_q  <= addr;
         op_f3_q    <= funct3;
         op_we_q    <= MemWrite & ~MemRead;
         op_wdata_q <= wdata_of(funct3, data_in);
         op_wstrb_q <= wstrb_of(funct3, addr[OFFW-1:0]);
         op_ctl_q   <= in_ctl;
      end
   end

   assign stall     = (state_q == REQ);
   assign mem_req   = (state_q == REQ);
   assign mem_we    = mem_req & op_we_q;
   assign mem_addr  = mem_req ? {op_addr_q[XLEN-1:OFFW], OFFW'(0)} : '0;
   assign mem_wdata = mem_we ? op_wdata_q : '0;
   assign mem_wstrb = mem_we ? op_wstrb_q : '0;

   assign out_valid      = ov_q;
   assign data_out       = dout_q;
   assign out_AluResult  = alu_q;
   assign out_MemToReg   = octl_q[8];
   assign out_RegWrite   = octl_q[7];
   assign out_RegDataSrc = octl_q[6];
   assign out_PCSrc      = octl_q[5];
   assign out_RegDest    = octl_q[4:0];
   assign misaligned     = mis_q;
   assign bus_err        = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Scoreboard bench: dut_a is XLEN=32 with TIMEOUT=4, dut_b is XLEN=64 with the
//   default TIMEOUT. Expected results are queued at issue and compared when the
//   DUT pulses out_valid.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   typedef struct {
      logic [63:0] dout;
      logic [63:0] alu;
      logic [8:0]  ctl;
      logic        mis;
      logic        berr;
   } exp_t;

   exp_t sbq_a[$];
   exp_t sbq_b[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // dut_a signals
   logic        a_in_valid, a_MemRead, a_MemWrite, a_mem_ack;
   logic [31:0] a_addr, a_data_in, a_mem_rdata;
   logic [2:0]  a_funct3;
   logic [8:0]  a_ictl;
   logic        a_stall, a_mem_req, a_mem_we, a_out_valid, a_mis, a_berr;
   logic [31:0] a_mem_addr, a_mem_wdata, a_data_out, a_alu;
   logic [3:0]  a_mem_wstrb;
   logic [8:0]  a_octl;

   // dut_b signals
   logic        b_in_valid, b_MemRead, b_MemWrite, b_mem_ack;
   logic [63:0] b_addr, b_data_in, b_mem_rdata;
   logic [2:0]  b_funct3;
   logic [8:0]  b_ictl;
   logic        b_stall, b_mem_req, b_mem_we, b_out_valid, b_mis, b_berr;
   logic [63:0] b_mem_addr, b_mem_wdata, b_data_out, b_alu;
   logic [7:0]  b_mem_wstrb;
   logic [8:0]  b_octl;

   mem_access_stage #(.XLEN(32), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .addr(a_addr), .data_in(a_data_in),
      .MemRead(a_MemRead), .MemWrite(a_MemWrite), .funct3(a_funct3),
      .in_MemToReg(a_ictl[8]), .in_RegWrite(a_ictl[7]), .in_RegDataSrc(a_ictl[6]),
      .in_PCSrc(a_ictl[5]), .in_RegDest(a_ictl[4:0]),
      .stall(a_stall), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
      .out_valid(a_out_valid), .data_out(a_data_out), .out_AluResult(a_alu),
      .out_MemToReg(a_octl[8]), .out_RegWrite(a_octl[7]), .out_RegDataSrc(a_octl[6]),
      .out_PCSrc(a_octl[5]), .out_RegDest(a_octl[4:0]), .misaligned(a_mis), .bus_err(a_berr)
   );

   mem_access_stage #(.XLEN(64)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .addr(b_addr), .data_in(b_data_in),
      .MemRead(b_MemRead), .MemWrite(b_MemWrite), .funct3(b_funct3),
      .in_MemToReg(b_ictl[8]), .in_RegWrite(b_ictl[7]), .in_RegDataSrc(b_ictl[6]),
      .in_PCSrc(b_ictl[5]), .in_RegDest(b_ictl[4:0]),
      .stall(b_stall), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
      .out_valid(b_out_valid), .data_out(b_data_out), .out_AluResult(b_alu),
      .out_MemToReg(b_octl[8]), .out_RegWrite(b_octl[7]), .out_RegDataSrc(b_octl[6]),
      .out_PCSrc(b_octl[5]), .out_RegDest(b_octl[4:0]), .misaligned(b_mis), .bus_err(b_berr)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] dout, input logic [63:0] alu,
                               input logic [8:0] ctl, input logic mis, input logic berr);
      exp_t e;
      e.dout = dout; e.alu = alu; e.ctl = ctl; e.mis = mis; e.berr = berr;
      return e;
   endfunction

   exp_t ea, eb;
   always @(negedge clk) begin
      if (a_out_valid) begin
         if (sbq_a.size() == 0) chk("a_unexpected_valid", 64'd1, 64'd0);
         else begin
            ea = sbq_a.pop_front();
            chk("a_data_out",   64'(a_data_out), ea.dout);
            chk("a_alu_result", 64'(a_alu),      ea.alu);
            chk("a_ctl",        64'(a_octl),     64'(ea.ctl));
            chk("a_misaligned", 64'(a_mis),      64'(ea.mis));
            chk("a_bus_err",    64'(a_berr),     64'(ea.berr));
         end
      end
      if (b_out_valid) begin
         if (sbq_b.size() == 0) chk("b_unexpected_valid", 64'd1, 64'd0);
         else begin
            eb = sbq_b.pop_front();
            chk("b_data_out",   b_data_out,  eb.dout);
            chk("b_alu_result", b_alu,       eb.alu);
            chk("b_ctl",        64'(b_octl), 64'(eb.ctl));
            chk("b_misaligned", 64'(b_mis),  64'(eb.mis));
            chk("b_bus_err",    64'(b_berr), 64'(eb.berr));
         end
      end
   end

   // Observations from the issue task: stall/request cycles and first-cycle bus values.
   int          nst, nreq;
   logic [63:0] f_addr, f_wdata;
   logic [7:0]  f_wstrb;
   logic        f_we;

   task automatic issue(input bit b, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d, input logic [8:0] ctl,
                        input int ack_at, input logic [63:0] rdat, input exp_t e);
      @(negedge clk);
      if (!b) begin
         a_in_valid = 1'b1; a_MemRead = rd; a_MemWrite = wr; a_funct3 = f3;
         a_addr = a[31:0]; a_data_in = d[31:0]; a_ictl = ctl;
         sbq_a.push_back(e);
      end else begin
         b_in_valid = 1'b1; b_MemRead = rd; b_MemWrite = wr; b_funct3 = f3;
         b_addr = a; b_data_in = d; b_ictl = ctl;
         sbq_b.push_back(e);
      end
      @(negedge clk);
      a_in_valid = 1'b0; a_MemRead = 1'b0; a_MemWrite = 1'b0;
      b_in_valid = 1'b0; b_MemRead = 1'b0; b_MemWrite = 1'b0;
      nst = 0; nreq = 0;
      f_addr = '0; f_wdata = '0; f_wstrb = '0; f_we = 1'b0;
      while ((b ? b_stall : a_stall) && nst < 300) begin
         nst++;
         if (b ? b_mem_req : a_mem_req) nreq++;
         if (nst == 1) begin
            f_addr  = b ? b_mem_addr  : 64'(a_mem_addr);
            f_wdata = b ? b_mem_wdata : 64'(a_mem_wdata);
            f_wstrb = b ? b_mem_wstrb : 8'(a_mem_wstrb);
            f_we    = b ? b_mem_we    : a_mem_we;
         end
         if (nst == ack_at) begin
            if (b) begin b_mem_ack = 1'b1; b_mem_rdata = rdat; end
            else   begin a_mem_ack = 1'b1; a_mem_rdata = rdat[31:0]; end
         end
         @(negedge clk);
         a_mem_ack = 1'b0; b_mem_ack = 1'b0;
      end
      if (nst >= 300) chk("stall_bound", 64'(nst), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int vld_cnt, stall_cnt;

   initial begin
      rst_n = 1'b0;
      a_in_valid = 0; a_MemRead = 0; a_MemWrite = 0; a_mem_ack = 0;
      a_addr = '0; a_data_in = '0; a_mem_rdata = '0; a_funct3 = '0; a_ictl = '0;
      b_in_valid = 0; b_MemRead = 0; b_MemWrite = 0; b_mem_ack = 0;
      b_addr = '0; b_data_in = '0; b_mem_rdata = '0; b_funct3 = '0; b_ictl = '0;
      repeat (2) @(negedge clk);
      chk("rst_a_mem_req",   64'(a_mem_req),   64'd0);
      chk("rst_a_stall",     64'(a_stall),     64'd0);
      chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_outs",      {a_alu, a_data_out}, 64'd0);
      chk("rst_a_ctl_flags", {a_octl, a_mis, a_berr}, 64'd0);
      chk("rst_b_stall",     64'(b_stall),     64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU passthrough
      issue(0, 0, 0, 3'b000, 64'h12345678, 64'h0, 9'h1A5, 0, 64'h0,
            mk(64'h0, 64'h12345678, 9'h1A5, 0, 0));
      chk("alu_no_stall", 64'(nst), 64'd0);

      // SB, ack on third cycle
      issue(0, 0, 1, 3'b000, 64'h1003, 64'hAABBCCDD, 9'h0C3, 3, 64'h0,
            mk(64'h0, 64'h1003, 9'h0C3, 0, 0));
      chk("sb_stall_cycles", 64'(nst), 64'd3);
      chk("sb_mem_addr",  f_addr,  64'h1000);
      chk("sb_wstrb",     64'(f_wstrb), 64'h8);
      chk("sb_wdata",     f_wdata, 64'hDDDDDDDD);
      chk("sb_we",        64'(f_we), 64'd1);

      // LBU / LB / LH
      issue(0, 1, 0, 3'b100, 64'h2001, 64'h0, 9'h081, 1, 64'h12348056,
            mk(64'h80, 64'h2001, 9'h081, 0, 0));
      chk("lbu_stall_cycles", 64'(nst), 64'd1);
      chk("lbu_mem_addr", f_addr, 64'h2000);
      chk("lbu_we",       64'(f_we), 64'd0);
      issue(0, 1, 0, 3'b000, 64'h2001, 64'h0, 9'h082, 2, 64'h12348056,
            mk(64'hFFFFFF80, 64'h2001, 9'h082, 0, 0));
      issue(0, 1, 0, 3'b001, 64'h2002, 64'h0, 9'h083, 1, 64'h12348056,
            mk(64'h00001234, 64'h2002, 9'h083, 0, 0));

      // Misaligned LW: no request, RegWrite suppressed
      issue(0, 1, 0, 3'b010, 64'h3002, 64'h0, 9'h184, 1, 64'h0,
            mk(64'h0, 64'h3002, 9'h104, 1, 0));
      chk("lw_mis_no_req", 64'(nreq), 64'd0);

      // Timeout
      issue(0, 1, 0, 3'b010, 64'h4000, 64'h0, 9'h1E5, 0, 64'h0,
            mk(64'h0, 64'h4000, 9'h165, 0, 1));
      chk("timeout_req_cycles", 64'(nreq), 64'd4);

      // SH, flags clear after fault
      issue(0, 0, 1, 3'b001, 64'h1002, 64'h0000BEEF, 9'h086, 2, 64'h0,
            mk(64'h0, 64'h1002, 9'h086, 0, 0));
      chk("sh_wstrb", 64'(f_wstrb), 64'hC);
      chk("sh_wdata", f_wdata, 64'hBEEFBEEF);

      // Illegal funct3 on 32-bit: 111 and D
      issue(0, 1, 0, 3'b111, 64'h5000, 64'h0, 9'h087, 1, 64'h0,
            mk(64'h0, 64'h5000, 9'h007, 1, 0));
      issue(0, 1, 0, 3'b011, 64'h5008, 64'h0, 9'h088, 1, 64'h0,
            mk(64'h0, 64'h5008, 9'h008, 1, 0));
      chk("ld32_no_req", 64'(nreq), 64'd0);

      // MemRead and MemWrite together behave as a load
      issue(0, 1, 1, 3'b010, 64'h6000, 64'h11111111, 9'h089, 1, 64'hCAFEBABE,
            mk(64'hCAFEBABE, 64'h6000, 9'h089, 0, 0));
      chk("rdwr_is_load", 64'(f_we), 64'd0);

      // Stray ack while idle is ignored
      @(negedge clk); a_mem_ack = 1'b1;
      @(negedge clk); a_mem_ack = 1'b0;
      chk("stray_ack_no_valid", 64'(a_out_valid), 64'd0);

      // Reset in the middle of a request
      @(negedge clk);
      a_in_valid = 1'b1; a_MemRead = 1'b1; a_funct3 = 3'b010; a_addr = 32'h7000; a_ictl = 9'h1FF;
      @(negedge clk);
      a_in_valid = 1'b0; a_MemRead = 1'b0;
      chk("rst_mid_pre_req", 64'(a_mem_req), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", 64'(a_mem_req), 64'd0);
      chk("rst_mid_stall",   64'(a_stall),   64'd0);
      chk("rst_mid_outs",    {a_alu, a_data_out}, 64'd0);
      chk("rst_mid_ctl",     {a_octl, a_out_valid, a_mis, a_berr}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_mid_after_req", 64'(a_mem_req), 64'd0);

      // 64-bit datapath
      issue(1, 1, 0, 3'b110, 64'h8004, 64'h0, 9'h091, 2, 64'hF0000001_00000000,
            mk(64'h00000000F0000001, 64'h8004, 9'h091, 0, 0));
      chk("lwu64_mem_addr", f_addr, 64'h8000);
      issue(1, 1, 0, 3'b010, 64'h8004, 64'h0, 9'h092, 1, 64'hF0000001_00000000,
            mk(64'hFFFFFFFFF0000001, 64'h8004, 9'h092, 0, 0));
      issue(1, 0, 1, 3'b011, 64'h9000, 64'h1122334455667788, 9'h013, 1, 64'h0,
            mk(64'h0, 64'h9000, 9'h013, 0, 0));
      chk("sd64_wstrb", 64'(f_wstrb), 64'hFF);
      chk("sd64_wdata", f_wdata, 64'h1122334455667788);
      issue(1, 0, 1, 3'b010, 64'h9004, 64'h1122334455667788, 9'h014, 1, 64'h0,
            mk(64'h0, 64'h9004, 9'h014, 0, 0));
      chk("sw64_wstrb", 64'(f_wstrb), 64'hF0);
      chk("sw64_wdata", f_wdata, 64'h5566778855667788);
      issue(1, 1, 0, 3'b011, 64'h9004, 64'h0, 9'h095, 1, 64'h0,
            mk(64'h0, 64'h9004, 9'h015, 1, 0));
      issue(1, 1, 0, 3'b011, 64'hA008, 64'h0, 9'h096, 1, 64'h8877665544332211,
            mk(64'h8877665544332211, 64'hA008, 9'h096, 0, 0));

      // Ten back-to-back ALU ops
      vld_cnt = 0; stall_cnt = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         b_in_valid = 1'b1; b_MemRead = 1'b0; b_MemWrite = 1'b0;
         b_addr = 64'h100 + 64'(i); b_ictl = 9'(i * 37);
         sbq_b.push_back(mk(64'h0, 64'h100 + 64'(i), 9'(i * 37), 0, 0));
         @(negedge clk);
         if (b_out_valid) vld_cnt++;
         if (b_stall) stall_cnt++;
      end
      b_in_valid = 1'b0;
      chk("b2b_valids", 64'(vld_cnt), 64'd10);
      chk("b2b_stalls", 64'(stall_cnt), 64'd0);

      repeat (3) @(negedge clk);
      chk("a_queue_drained", 64'(sbq_a.size()), 64'd0);
      chk("b_queue_drained", 64'(sbq_b.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
